// File: rtl/mem_arb.sv
// mem_arb: serialises icache/dcache line fills and dcache writebacks onto the single QSPI engine.
// Optional feature macro: MEMARB_RR_EN (icache/dcache fill fairness); default build is fixed priority.
module mem_arb #(
    parameter  int PA          = 22,
    parameter  int LINE_LENGTH = 4,
    localparam int LB          = $clog2(LINE_LENGTH),
    localparam int TW          = PA - LB
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_pull,
    input  logic [TW-1:0] i_tag,
    input  logic          d_push,
    input  logic [TW-1:0] d_vtag,
    input  logic          d_pull,
    input  logic [TW-1:0] d_tag,
    input  logic          q_done,
    output logic          q_req,
    output logic          q_i_d,
    output logic          q_write,
    output logic          q_mem,
    output logic [TW-1:0] q_paddr,
    output logic          i_done,
    output logic          d_push_done,
    output logic          d_pull_done,
    output logic          busy
);

    typedef enum logic [2:0] {IDLE, WB, FILL_D, FILL_I, DONE} state_t;

    state_t        state_q;
    logic          lock_q;
    logic          pick_i_d;
    logic          gnt_wb_d;
    logic          gnt_fd_d;
    logic          gnt_fi_d;
    logic [TW-1:0] gnt_tag_d;
`ifdef MEMARB_RR_EN
    logic          last_i_q;
`endif

    always_comb begin
        pick_i_d = 1'b0;
        gnt_wb_d = 1'b0;
        gnt_fd_d = 1'b0;
        gnt_fi_d = 1'b0;
        if (state_q == IDLE) begin
            if (lock_q) begin
                // Keep the refill glued to its writeback: only d_pull may win.
                gnt_fd_d = d_pull;
            end else begin
`ifdef MEMARB_RR_EN
                pick_i_d = i_pull && (!(d_push || d_pull) || !last_i_q);
`else
                pick_i_d = i_pull && !(d_push || d_pull);
`endif
                gnt_fi_d = pick_i_d;
                gnt_wb_d = !pick_i_d && d_push;
                gnt_fd_d = !pick_i_d && !d_push && d_pull;
            end
        end
        gnt_tag_d = gnt_wb_d ? d_vtag : (gnt_fd_d ? d_tag : i_tag);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            lock_q      <= 1'b0;
            q_req       <= 1'b0;
            q_i_d       <= 1'b0;
            q_write     <= 1'b0;
            q_mem       <= 1'b0;
            q_paddr     <= '0;
            i_done      <= 1'b0;
            d_push_done <= 1'b0;
            d_pull_done <= 1'b0;
            busy        <= 1'b0;
`ifdef MEMARB_RR_EN
            last_i_q    <= 1'b0;
`endif
        end else begin
            i_done      <= 1'b0;
            d_push_done <= 1'b0;
            d_pull_done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (gnt_wb_d || gnt_fd_d || gnt_fi_d) begin
                        state_q <= gnt_wb_d ? WB : (gnt_fd_d ? FILL_D : FILL_I);
                        q_req   <= 1'b1;
                        busy    <= 1'b1;
                        q_write <= gnt_wb_d;
                        q_i_d   <= gnt_fi_d;
                        q_paddr <= gnt_tag_d;
                        q_mem   <= &gnt_tag_d[TW-1 -: 7];
                        lock_q  <= 1'b0;
                    end else if (!d_pull) begin
                        lock_q  <= 1'b0;
                    end
`ifdef MEMARB_RR_EN
                    if (gnt_fi_d) begin
                        last_i_q <= 1'b1;
                    end else if (gnt_wb_d || gnt_fd_d) begin
                        last_i_q <= 1'b0;
                    end
`endif
                end
                WB, FILL_D, FILL_I: begin
                    if (q_done) begin
                        state_q     <= DONE;
                        q_req       <= 1'b0;
                        d_push_done <= (state_q == WB);
                        d_pull_done <= (state_q == FILL_D);
                        i_done      <= (state_q == FILL_I);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                    lock_q  <= q_write;
                    q_write <= 1'b0;
                    q_i_d   <= 1'b0;
                    q_mem   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: directed reset/timing cases, then random request rounds checked by a scoreboard.
module tb_mem_arb;
    localparam int PA = 22;
    localparam int LB = 2;
    localparam int TW = PA - LB;
    localparam logic [PA-1:0] DV_BYTE = 22'h3F8001;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_pull, d_push, d_pull;
    logic [TW-1:0] i_tag, d_vtag, d_tag;
    logic          q_done_dir = 1'b0;
    logic          q_done_rsp = 1'b0;
    logic          q_done;
    logic          q_req, q_i_d, q_write, q_mem;
    logic [TW-1:0] q_paddr;
    logic          i_done, d_push_done, d_pull_done, busy;

    assign q_done = q_done_dir | q_done_rsp;

    always #5 clk = ~clk;

    mem_arb dut (
        .clk(clk), .reset(reset),
        .i_pull(i_pull), .i_tag(i_tag),
        .d_push(d_push), .d_vtag(d_vtag),
        .d_pull(d_pull), .d_tag(d_tag),
        .q_done(q_done),
        .q_req(q_req), .q_i_d(q_i_d), .q_write(q_write), .q_mem(q_mem),
        .q_paddr(q_paddr),
        .i_done(i_done), .d_push_done(d_push_done), .d_pull_done(d_pull_done),
        .busy(busy)
    );

    // kind: 0 = writeback, 1 = dcache fill, 2 = icache fill
    typedef struct {
        int            kind;
        logic [TW-1:0] tag;
        bit            first;
    } xfer_t;

    xfer_t exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    bit    mon_en = 1'b0;
    bit    model_last_i = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [2:0] done_vec(input int kind);
        // order {i_done, d_push_done, d_pull_done}
        case (kind)
            0:       return 3'b010;
            1:       return 3'b001;
            default: return 3'b100;
        endcase
    endfunction

    // Monitor plus QSPI responder in one process so the expected-done flag is race free.
    bit            prev_req = 1'b0;
    bit            exp_done_now = 1'b0;
    int            qwait = -1;
    int            cyc = 0;
    int            last_done_cyc = 0;
    int            prev_kind = -1;
    xfer_t         cur;
    logic [PA-1:0] byte_addr;

    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            chk("done_pulses", 32'({i_done, d_push_done, d_pull_done}),
                exp_done_now ? 32'(done_vec(cur.kind)) : 32'd0);
            if (exp_done_now) begin
                chk("req_drop_after_done", 32'(q_req), 32'd0);
                last_done_cyc = cyc;
                prev_kind = cur.kind;
            end
            exp_done_now = 1'b0;
            if (q_req && !prev_req) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_grant: got paddr %0h expected no transfer", q_paddr);
                end else begin
                    cur = exp_q.pop_front();
                    byte_addr = {cur.tag, {LB{1'b0}}};
                    chk("q_write", 32'(q_write), 32'(cur.kind == 0));
                    chk("q_i_d", 32'(q_i_d), 32'(cur.kind == 2));
                    chk("q_paddr", 32'(q_paddr), 32'(cur.tag));
                    chk("q_mem", 32'(q_mem), 32'((byte_addr >> (PA - 7)) == 22'h7f));
                    chk("busy_in_xfer", 32'(busy), 32'd1);
                    if (!cur.first)
                        chk("idle_gap", 32'(cyc - last_done_cyc),
                            (prev_kind == 0 && cur.kind == 2) ? 32'd3 : 32'd2);
                end
            end
            prev_req = q_req;
            q_done_rsp = 1'b0;
            if (!q_req) begin
                qwait = -1;
                if ($urandom_range(0, 9) == 0) q_done_rsp = 1'b1;
            end else begin
                if (qwait < 0) qwait = int'($urandom_range(0, 3));
                if (qwait == 0) begin
                    q_done_rsp = 1'b1;
                    qwait = 99;
                    exp_done_now = 1'b1;
                end else if (qwait != 99) begin
                    qwait--;
                end
            end
        end else begin
            prev_req = q_req;
            q_done_rsp = 1'b0;
        end
    end

    // Reference model: order of service from the arbitration rules, then drive the requesters
    // like caches (hold the level until the matching done pulse).
    task automatic run_round(input bit ip, input bit pp, input bit dp,
                             input logic [TW-1:0] it, input logic [TW-1:0] vt,
                             input logic [TW-1:0] dt);
        bit    pi, pu, pd, lk, first, data, take_i;
        xfer_t x;
        pi = ip; pu = pp; pd = dp; lk = 1'b0; first = 1'b1;
        while (pi || pu || pd) begin
            if (lk) begin
                lk = 1'b0;
                if (pd) begin
                    x.kind = 1; x.tag = dt; x.first = first; exp_q.push_back(x);
                    pd = 1'b0; first = 1'b0; model_last_i = 1'b0;
                end
                continue;
            end
            data = pu || pd;
            if (!data) take_i = pi;
            else if (!pi) take_i = 1'b0;
`ifdef MEMARB_RR_EN
            else take_i = (model_last_i == 1'b0);
`else
            else take_i = 1'b0;
`endif
            if (take_i) begin
                x.kind = 2; x.tag = it; pi = 1'b0; model_last_i = 1'b1;
            end else if (pu) begin
                x.kind = 0; x.tag = vt; pu = 1'b0; lk = 1'b1; model_last_i = 1'b0;
            end else begin
                x.kind = 1; x.tag = dt; pd = 1'b0; model_last_i = 1'b0;
            end
            x.first = first;
            first = 1'b0;
            exp_q.push_back(x);
        end
        i_tag = it; d_vtag = vt; d_tag = dt;
        i_pull = ip; d_push = pp; d_pull = dp;
        @(negedge clk);
        chk("grant_latency", 32'(q_req), 32'd1);
        for (int c = 0; c < 300 && (i_pull || d_push || d_pull); c++) begin
            @(negedge clk);
            if (i_done) i_pull = 1'b0;
            if (d_push_done) d_push = 1'b0;
            if (d_pull_done) d_pull = 1'b0;
        end
        chk("round_complete", 32'({i_pull, d_push, d_pull}), 32'd0);
        repeat (2 + $urandom_range(0, 2)) @(negedge clk);
    endtask

    function automatic logic [TW-1:0] rtag();
        logic [TW-1:0] t;
        t = TW'($urandom);
        if ($urandom_range(0, 1) == 1) t[TW-1 -: 7] = 7'h7f;
        return t;
    endfunction

    initial begin
        bit ip, pp, dp;
        reset = 1'b1;
        i_pull = 1'b0; d_push = 1'b0; d_pull = 1'b0;
        i_tag = '0; d_vtag = '0; d_tag = '0;
        repeat (3) @(negedge clk);
        chk("rst_q_req", 32'(q_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_flags", 32'({q_write, q_i_d, q_mem}), 32'd0);
        chk("rst_paddr", 32'(q_paddr), 32'd0);
        chk("rst_dones", 32'({i_done, d_push_done, d_pull_done}), 32'd0);
        reset = 1'b0;

        // icache fill alone, exact cycle timing
        i_tag = 20'h12345; i_pull = 1'b1;
        @(negedge clk);
        chk("if_q_req", 32'(q_req), 32'd1);
        chk("if_q_i_d", 32'(q_i_d), 32'd1);
        chk("if_q_write", 32'(q_write), 32'd0);
        chk("if_paddr", 32'(q_paddr), 32'h12345);
        repeat (3) @(negedge clk);
        chk("if_wait_req", 32'(q_req), 32'd1);
        q_done_dir = 1'b1;
        @(negedge clk);
        q_done_dir = 1'b0;
        chk("if_i_done", 32'({i_done, d_push_done, d_pull_done}), 32'b100);
        chk("if_done_req", 32'(q_req), 32'd0);
        chk("if_done_busy", 32'(busy), 32'd1);
        i_pull = 1'b0;
        @(negedge clk);
        chk("if_pulse_width", 32'(i_done), 32'd0);
        chk("if_idle_busy", 32'(busy), 32'd0);

        // spurious q_done in IDLE
        q_done_dir = 1'b1;
        @(negedge clk);
        q_done_dir = 1'b0;
        chk("spur_dones", 32'({i_done, d_push_done, d_pull_done}), 32'd0);
        chk("spur_state", 32'({busy, q_req}), 32'd0);

        // reset while a dcache fill is on the bus
        d_tag = 20'h00010; d_pull = 1'b1;
        @(negedge clk);
        chk("mr_q_req", 32'(q_req), 32'd1);
        chk("mr_paddr", 32'(q_paddr), 32'h10);
        reset = 1'b1;
        @(negedge clk);
        chk("mr_after_rst", 32'({q_req, busy, d_pull_done}), 32'd0);
        chk("mr_paddr_clr", 32'(q_paddr), 32'd0);
        reset = 1'b0; d_pull = 1'b0; q_done_dir = 1'b1;
        @(negedge clk);
        q_done_dir = 1'b0;
        chk("mr_late_done", 32'({i_done, d_push_done, d_pull_done, busy}), 32'd0);

        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_last_i = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;

        // dirty miss with icache pending; victim address given as a byte address
        run_round(1'b1, 1'b1, 1'b1, 20'h0abcd, DV_BYTE[PA-1:LB], 20'h00010);
        for (int r = 0; r < 40; r++) begin
            ip = 1'($urandom_range(0, 1));
            pp = 1'($urandom_range(0, 1));
            dp = 1'($urandom_range(0, 1));
            if (!(ip || pp || dp)) ip = 1'b1;
            run_round(ip, pp, dp, rtag(), rtag(), rtag());
        end
        mon_en = 1'b0;
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
